// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART receiver and transmitter so both ends of the
// link agree on bit timing and frame width.
//   UART_CLKS_PER_BIT : system clocks per serial bit
//   UART_DATA_BITS    : data bits per 8N1 frame
//   uart_rx_state_t   : receiver frame-tracking states
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 4;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/shift_reg_serial_in_par_out.sv
// shift_reg_serial_in_par_out
// Serial-in, parallel-out register. Each shift moves the contents one place
// toward bit 0 and inserts bit_in at the MSB, so after M shifts the first bit
// shifted in sits in bus_out[0] (LSB-first serial order).
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous active-high reset, clears the register
//   bit_in  : serial data to insert
//   shift   : shift enable, one bit per enabled clock
//   bus_out : parallel register contents
module shift_reg_serial_in_par_out #(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_in,
  input  logic         shift,
  output logic [M-1:0] bus_out
);

  generate
    if (M == 1) begin : g_single
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          bus_out <= '0;
        end else if (shift) begin
          bus_out <= bit_in;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          bus_out <= '0;
        end else if (shift) begin
          bus_out <= {bit_in, bus_out[M-1:1]};
        end
      end
    end
  endgenerate

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
// Serial-to-parallel UART receiver for 8N1-style frames (start bit 0,
// DATA_BITS data bits LSB first, one stop bit 1) at CLKS_PER_BIT system clocks
// per bit. The line is double-flopped into the clock domain, each bit is
// sampled near its centre, and a completed byte is presented with a one-cycle
// valid strobe. A low stop bit raises a one-cycle frame_err and the receiver
// then waits for the line to return high before hunting for a new start bit.
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-high reset
//   bit_in    : serial line, idles high, asynchronous to clk
//   byte_out  : last correctly framed byte, held until the next good frame
//   valid     : one-cycle pulse, byte_out is new in the same cycle
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   busy      : high whenever the receiver is not idle
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] byte_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // cnt counts clocks since the last state entry, so the compare value is one
  // less than the number of edges to wait.
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_rx_state_t       state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic                 sync1, sync2;
  logic                 shift;
  logic                 load;
  logic                 valid_d;
  logic                 frame_err_d;
  logic [DATA_BITS-1:0] shift_bus;

  // Synchronizer: both flops reset high so an idle line never looks like a
  // start bit straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bit_in;
      sync2 <= sync1;
    end
  end

  // State, counters and output strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      valid     <= valid_d;
      frame_err <= frame_err_d;
    end
  end

  // Next-state logic. Every timed state waits on cnt and restarts it at 0 when
  // it samples, which keeps each later sample one full bit after the previous.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = idx;
    shift       = 1'b0;
    load        = 1'b0;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    case (state)
      IDLE: begin
        if (!sync2) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt == HALF_M1) begin
          cnt_d = '0;
          // Mid-bit recheck rejects short low glitches on an idle line.
          if (!sync2) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_d = '0;
          shift = 1'b1;
          if (idx == LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_d = '0;
          if (sync2) begin
            load    = 1'b1;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      WAIT_IDLE: begin
        // A break or stuck-low line must not be decoded as a stream of frames.
        if (sync2) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  shift_reg_serial_in_par_out #(
    .M(DATA_BITS)
  ) u_shift (
    .clk    (clk),
    .reset  (reset),
    .bit_in (sync2),
    .shift  (shift),
    .bus_out(shift_bus)
  );

  // Output byte: updated only by a correctly framed byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_out <= '0;
    end else if (load) begin
      byte_out <= shift_bus;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
// Directed bench for uart_receiver with the default 4 clocks per bit and
// 8 data bits. Line stimulus changes on falling clock edges; a monitor
// records valid/frame_err pulses and busy cycles on falling edges.
module tb_uart_receiver;

  localparam int CPB   = 4;
  localparam int DBITS = 8;

  logic             clk;
  logic             reset;
  logic             bit_in;
  logic [DBITS-1:0] byte_out;
  logic             valid;
  logic             frame_err;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc      = 0;
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int busy_cnt  = 0;
  int last_ferr_cyc = 0;
  int          valid_cycs[$];
  logic [7:0]  valid_bytes[$];

  uart_receiver #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DBITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bit_in   (bit_in),
    .byte_out (byte_out),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      valid_cycs.push_back(cyc);
      valid_bytes.push_back(byte_out);
    end
    if (frame_err === 1'b1) begin
      ferr_cnt      = ferr_cnt + 1;
      last_ferr_cyc = cyc;
    end
    if (busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  task automatic drive_bit(input logic b);
    bit_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Sends one frame starting at the current falling edge; returns the cycle
  // count at which the start bit was driven low.
  task automatic send_frame(input logic [7:0] data, input logic stop, output int fall_cyc);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DBITS; i++) drive_bit(data[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    bit_in = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_checks++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h want 00", byte_out); end
    reset = 1'b0;
    repeat (100) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
    n_checks++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL idle_valid_count: got %0d want 0", valid_cnt); end
    n_checks++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL idle_byte: got %h want 00", byte_out); end
  endtask

  task automatic test_single_frame();
    int f, v0, e0;
    v0 = valid_cnt; e0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, f);
    repeat (10) @(negedge clk);
    n_checks++; if (valid_cnt !== v0 + 1) begin n_fail++; $display("FAIL a5_valid_count: got %0d want %0d", valid_cnt - v0, 1); end
    if (valid_cnt == v0 + 1) begin
      n_checks++; if (valid_cycs[v0] !== f + 41) begin n_fail++; $display("FAIL a5_latency: got %0d want %0d", valid_cycs[v0] - f, 41); end
      n_checks++; if (valid_bytes[v0] !== 8'hA5) begin n_fail++; $display("FAIL a5_byte_at_valid: got %h want a5", valid_bytes[v0]); end
    end
    n_checks++; if (byte_out !== 8'hA5) begin n_fail++; $display("FAIL a5_byte_held: got %h want a5", byte_out); end
    n_checks++; if (ferr_cnt !== e0) begin n_fail++; $display("FAIL a5_ferr: got %0d want 0", ferr_cnt - e0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL a5_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int f1, f2, v0;
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, f1);
    send_frame(8'hFF, 1'b1, f2);
    repeat (10) @(negedge clk);
    n_checks++; if (valid_cnt !== v0 + 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d want 2", valid_cnt - v0); end
    if (valid_cnt == v0 + 2) begin
      n_checks++; if (valid_cycs[v0] !== f1 + 41) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 41", valid_cycs[v0] - f1); end
      n_checks++; if (valid_cycs[v0+1] - valid_cycs[v0] !== 40) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 40", valid_cycs[v0+1] - valid_cycs[v0]); end
      n_checks++; if (valid_bytes[v0] !== 8'h00) begin n_fail++; $display("FAIL b2b_first_byte: got %h want 00", valid_bytes[v0]); end
      n_checks++; if (valid_bytes[v0+1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second_byte: got %h want ff", valid_bytes[v0+1]); end
    end
    n_checks++; if (byte_out !== 8'hFF) begin n_fail++; $display("FAIL b2b_byte_held: got %h want ff", byte_out); end
  endtask

  task automatic test_glitch();
    int v0, e0, b0;
    v0 = valid_cnt; e0 = ferr_cnt; b0 = busy_cnt;
    bit_in = 1'b0;
    @(negedge clk);
    bit_in = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++; if (busy_cnt - b0 !== 2) begin n_fail++; $display("FAIL glitch_busy_cycles: got %0d want 2", busy_cnt - b0); end
    n_checks++; if (valid_cnt !== v0) begin n_fail++; $display("FAIL glitch_valid: got %0d want 0", valid_cnt - v0); end
    n_checks++; if (ferr_cnt !== e0) begin n_fail++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - e0); end
    n_checks++; if (byte_out !== 8'hFF) begin n_fail++; $display("FAIL glitch_byte: got %h want ff", byte_out); end
  endtask

  task automatic test_frame_error();
    int f, v0, e0;
    v0 = valid_cnt; e0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, f);
    repeat (20) @(negedge clk);
    n_checks++; if (ferr_cnt !== e0 + 1) begin n_fail++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - e0); end
    n_checks++; if (last_ferr_cyc !== f + 41) begin n_fail++; $display("FAIL ferr_timing: got %0d want 41", last_ferr_cyc - f); end
    n_checks++; if (valid_cnt !== v0) begin n_fail++; $display("FAIL ferr_valid: got %0d want 0", valid_cnt - v0); end
    n_checks++; if (byte_out !== 8'hFF) begin n_fail++; $display("FAIL ferr_byte_kept: got %h want ff", byte_out); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_low_line: got %b want 1", busy); end
    bit_in = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_recover: got %b want 0", busy); end
    send_frame(8'h3C, 1'b1, f);
    repeat (10) @(negedge clk);
    n_checks++; if (valid_cnt !== v0 + 1) begin n_fail++; $display("FAIL ferr_next_valid: got %0d want 1", valid_cnt - v0); end
    n_checks++; if (byte_out !== 8'h3C) begin n_fail++; $display("FAIL ferr_next_byte: got %h want 3c", byte_out); end
    n_checks++; if (ferr_cnt !== e0 + 1) begin n_fail++; $display("FAIL ferr_next_ferr: got %0d want 1", ferr_cnt - e0); end
  endtask

  task automatic test_reset_mid_frame();
    int f, v0, e0;
    logic [7:0] d;
    d = 8'h5A;
    v0 = valid_cnt; e0 = ferr_cnt;
    bit_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    bit_in = d[4];
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL mid_reset_byte: got %h want 00", byte_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", valid); end
    bit_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    n_checks++; if (valid_cnt !== v0) begin n_fail++; $display("FAIL mid_no_valid: got %0d want 0", valid_cnt - v0); end
    n_checks++; if (ferr_cnt !== e0) begin n_fail++; $display("FAIL mid_no_ferr: got %0d want 0", ferr_cnt - e0); end
    send_frame(8'h81, 1'b1, f);
    repeat (10) @(negedge clk);
    n_checks++; if (valid_cnt !== v0 + 1) begin n_fail++; $display("FAIL post_reset_valid: got %0d want 1", valid_cnt - v0); end
    if (valid_cnt == v0 + 1) begin
      n_checks++; if (valid_cycs[v0] !== f + 41) begin n_fail++; $display("FAIL post_reset_latency: got %0d want 41", valid_cycs[v0] - f); end
    end
    n_checks++; if (byte_out !== 8'h81) begin n_fail++; $display("FAIL post_reset_byte: got %h want 81", byte_out); end
  endtask

  initial begin
    reset  = 1'b1;
    bit_in = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; counterpart of the team's UART transmitter.
- Recovers 8N1 frames from an asynchronous line, clocked at CLKS_PER_BIT system clocks per bit:
  - start bit = 0
  - DATA_BITS data bits, LSB first
  - one stop bit = 1
- Presents each received byte with a 1-cycle valid strobe and flags framing errors.
- Sits at the FPGA pin side, feeding downstream byte consumers.

Parameters:
- CLKS_PER_BIT, 4, system clocks per UART bit; must be >= 2. HALF = CLKS_PER_BIT/2, integer division.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- bit_in  input  1  serial line; idles high; asynchronous to clk.
- byte_out  output  DATA_BITS  last correctly framed byte; held until the next good frame.
- valid  output  1  1-cycle pulse; byte_out is new in that same cycle.
- frame_err  output  1  1-cycle pulse when the stop bit is sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state=IDLE, all counters 0.
  - Both synchronizer flops = 1, so no false start is seen after reset.
  - byte_out=0, valid=0, frame_err=0, busy=0.
  - Reset mid-frame aborts the frame; no valid and no frame_err for that frame.
- Synchronizer: bit_in passes through 2 flops (sync1 -> sync2). Only sync2 is used internally.
- Bit counter: cnt width $clog2(CLKS_PER_BIT).
- Bit index: idx, 0..DATA_BITS-1.
- Let edge k be the rising edge at which the state enters START. All sample edges below are counted from k.
- IDLE:
  - On an edge where sync2==0: go to START, cnt=0.
  - With bit_in falling before edge E0, sync2 is low after E1, so START is entered at E2.
- START:
  - cnt increments each clock. The start bit is sampled at edge k+HALF.
  - If sync2==0: go to DATA, cnt=0, idx=0.
  - If sync2==1 (glitch): return to IDLE. No outputs change.
- DATA:
  - Data bit i is sampled at edge k+HALF+(i+1)*CLKS_PER_BIT.
  - Each sample is shifted into the shift register LSB first: the first received bit ends in byte_out[0].
  - After bit DATA_BITS-1 is sampled: go to STOP.
- STOP:
  - The stop bit is sampled at edge k+HALF+(DATA_BITS+1)*CLKS_PER_BIT.
  - If sync2==1: byte_out <= shift register, valid=1 for exactly one cycle, go to IDLE.
  - If sync2==0: frame_err=1 for one cycle, byte_out unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until sync2==1, then go to IDLE. This prevents a break or stuck-low line from being read as repeated frames.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. IDLE detects it on the first edge after the return to IDLE.
- Latency with defaults: valid is high in the cycle after edge E0+40, where E0 is the first edge sampling bit_in low.
- No input backpressure: a byte not consumed before the next valid is overwritten.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum uart_rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE}
  - localparam UART_CLKS_PER_BIT=4 and UART_DATA_BITS=8, shared with the transmitter so both ends agree on timing.
- Sub-module shift_reg_serial_in_par_out, parameter M:
  - Ports: clk, reset, bit_in, shift, bus_out.
  - Shifts right with MSB insertion so that after M shifts the first bit sits in bus_out[0].
  - It is the mirror of the existing parallel-in serial-out register.

Test Plan:
- Reset released, line held high for 100 clocks -> busy=0, valid never asserted, byte_out=0x00.
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), 4 clocks per bit -> valid pulses exactly once, 40 edges after the start-bit fall; byte_out=0xA5; frame_err=0.
- Frames 0x00 then 0xFF back-to-back, no idle gap -> two valid pulses 40 clocks apart; byte_out=0x00, then 0xFF.
- Low glitch of 1 clock on an idle line -> START aborts at edge k+2; busy high for 2 cycles only; no valid, no frame_err.
- Frame 0x3C with stop bit forced low, line held low 20 more clocks -> frame_err pulses once; byte_out keeps the previous value; busy stays high until the line rises; the next good frame 0x3C then yields valid.
- Reset asserted asynchronously mid-DATA (after bit 3) -> outputs zero immediately; no valid. A subsequent clean frame 0x81 is received correctly.
